seq_mac_tile_sched: RTL and testbench
=====================================

# seq_mac_tile_sched

Tile scheduler that sequences one `seq_MAC` instance over a K-dimension reduction split into `num_tiles` consecutive M×K·K×N tiles. It accepts a job descriptor, fetches one operand tile at a time from an upstream stream, and launches the MAC. The MAC result D of each tile is chained back as C of the next tile, so the final D = C0 + Σ A_t·B_t. It sits between the operand buffer/DMA front-end and the MAC array, and owns the MAC's `valid_in`/`ready_in`/`valid_out`/`ready_out` handshakes.

## Interface
- M, 2, rows of A tile
- N, 2, columns of B tile
- K, 2, inner dimension per tile
- MAX_WIDTH, 16, max operand width in bits
- P, 2, bits per serial step; BW = $clog2(MAX_WIDTH/P)+1 is the bit-size field width
- MAX_TILES, 16, max tiles per job; TW = $clog2(MAX_TILES+1)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- desc_valid_i / desc_ready_o  in/out  1  descriptor handshake
- desc_tiles_i  in  TW  number of tiles (0..MAX_TILES)
- desc_bsa_i, desc_bsb_i  in  BW  A/B width in P-bit chunks
- desc_c_i  in  32×[M][N]  initial accumulator C0
- op_valid_i / op_ready_o  in/out  1  operand tile handshake
- op_a_i  in  MAX_WIDTH×[M][K]; op_b_i  in  MAX_WIDTH×[K][N]  signed tile operands
- mac_a_o, mac_b_o, mac_c_o  out  same shapes  registered MAC operands
- mac_bsa_o, mac_bsb_o  out  BW  latched bit sizes
- mac_valid_o  out 1; mac_ready_i  in 1  MAC launch (to `valid_in`/from `ready_in`)
- mac_valid_i  in 1; mac_ready_o  out 1  MAC result (from `valid_out`/to `ready_out`)
- mac_d_i  in  32×[M][N]  MAC result
- res_valid_o / res_ready_i  out/in  1  result handshake
- res_d_o  out  32×[M][N]  final accumulator
- res_err_o  out  1  descriptor was invalid (qualified by res_valid_o)
- busy_o  out  1  state ≠ IDLE
- tile_idx_o  out  TW  tiles completed in current job

## Operation
- States: IDLE, FETCH, LAUNCH, WAIT, DONE.
- IDLE: desc_ready_o=1. On handshake, latch tiles, bsa, bsb and C0 into acc, and clear tile_idx. Invalid if bsa or bsb is 0 or > MAX_WIDTH/P, or tiles > MAX_TILES: set err and go to DONE. tiles==0 also goes to DONE (err=0, result=C0). Otherwise go to FETCH.
- FETCH: op_ready_o=1. On op handshake, register op_a/op_b into mac_a/mac_b; go to LAUNCH.
- LAUNCH: mac_valid_o=1 with mac_c_o=acc. On mac_ready_i, go to WAIT. mac_a/b/c/bs hold stable from LAUNCH until WAIT exits.
- WAIT: mac_ready_o=1. On mac_valid_i: acc←mac_d_i, tile_idx++. If tile_idx+1==tiles go to DONE, else go to FETCH.
- DONE: res_valid_o=1, res_d_o=acc, res_err_o=err. On res_ready_i go to IDLE. res_* are held stable while res_ready_i is low.
- Arithmetic: chaining is a bit-exact 32-bit copy with no saturation. Wrap-around is inherited from the MAC.
- Only one handshake port is active per state. Simultaneous valids on inactive ports are ignored and never consumed.
- mac_valid_i outside WAIT is ignored (mac_ready_o=0 there).

## Timing
- Reset: state=IDLE and all registers 0. Outputs are 0 except desc_ready_o, which is 1 after reset deasserts. In reset: mac_valid_o=0, mac_ready_o=0, op_ready_o=0, res_valid_o=0, busy_o=0, tile_idx_o=0.
- Descriptor accept → op_ready_o high on the next cycle.
- Op accept → mac_valid_o high on the next cycle.
- mac_valid_i accepted in cycle t → acc updated at t+1, and at t+1 either op_ready_o or res_valid_o is high.
- Per-tile overhead is 3 cycles plus MAC latency, assuming zero upstream stall.
- Result accept → desc_ready_o high the following cycle. There is one bubble cycle between jobs, and no descriptor is accepted while in DONE.
- Async reset mid-job aborts immediately. There is no partial result and no pending MAC handshake. The MAC shares rst_ni.
- All outputs are registered or decoded from registered state only. No combinational input→output path exists.

## Test plan
- Single tile, M=N=K=2, bsa=bsb=4: A=[[1,2],[3,4]], B=I, C0=0 → res_d=[[1,2],[3,4]], res_err=0, tile_idx=1.
- Chaining, 3 tiles: each A=2I, B=3I, C0=all 10 → diagonal 28, off-diagonal 10. mac_c_o on tile 2 equals tile-1 D (diagonal 16).
- Signed and minimum width: bsa=1, bsb=7. A=−1 everywhere, B: row 0 = [−64, 63], row 1 = [−64, 63], C0=5 → D=[[133,−121],[133,−121]] (5 − (B[0][j]+B[1][j])).
- tiles=0 with C0=all 7 → res_valid 1 cycle after accept, res_d=7, no op_ready_o or mac_valid_o pulses. bsa=0 → res_err=1 with res_d=C0.
- Backpressure: hold op_valid low for 5 cycles, mac_ready low for 4 cycles in LAUNCH, and res_ready low for 6 cycles → operands, mac_c and res_d stay stable, no duplicate launch, and the final value is correct.
- Reset asserted in WAIT of tile 2 of 3 → all outputs 0 and desc_ready_o=1 after release. A new single-tile job then completes correctly.

Source files
------------

// File: rtl/seq_mac_tile_sched.sv
// Tile scheduler: sequences one seq_MAC over a K-split reduction,
// chaining each tile's D back in as the next tile's C.
module seq_mac_tile_sched #(
    parameter int M         = 2,
    parameter int N         = 2,
    parameter int K         = 2,
    parameter int MAX_WIDTH = 16,
    parameter int P         = 2,
    parameter int MAX_TILES = 16,
    localparam int BW = $clog2(MAX_WIDTH/P) + 1,
    localparam int TW = $clog2(MAX_TILES + 1)
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 desc_valid_i,
    output logic                                 desc_ready_o,
    input  logic [TW-1:0]                        desc_tiles_i,
    input  logic [BW-1:0]                        desc_bsa_i,
    input  logic [BW-1:0]                        desc_bsb_i,
    input  logic [M-1:0][N-1:0][31:0]            desc_c_i,
    input  logic                                 op_valid_i,
    output logic                                 op_ready_o,
    input  logic [M-1:0][K-1:0][MAX_WIDTH-1:0]   op_a_i,
    input  logic [K-1:0][N-1:0][MAX_WIDTH-1:0]   op_b_i,
    output logic [M-1:0][K-1:0][MAX_WIDTH-1:0]   mac_a_o,
    output logic [K-1:0][N-1:0][MAX_WIDTH-1:0]   mac_b_o,
    output logic [M-1:0][N-1:0][31:0]            mac_c_o,
    output logic [BW-1:0]                        mac_bsa_o,
    output logic [BW-1:0]                        mac_bsb_o,
    output logic                                 mac_valid_o,
    input  logic                                 mac_ready_i,
    input  logic                                 mac_valid_i,
    output logic                                 mac_ready_o,
    input  logic [M-1:0][N-1:0][31:0]            mac_d_i,
    output logic                                 res_valid_o,
    input  logic                                 res_ready_i,
    output logic [M-1:0][N-1:0][31:0]            res_d_o,
    output logic                                 res_err_o,
    output logic                                 busy_o,
    output logic [TW-1:0]                        tile_idx_o
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LAUNCH,
        WAIT,
        DONE
    } state_e;

    localparam logic [BW-1:0] MAX_BS = BW'(MAX_WIDTH / P);
    localparam logic [TW-1:0] MAX_T  = TW'(MAX_TILES);

    state_e state_q, state_d;

    logic [TW-1:0]                      tiles_q;
    logic [TW-1:0]                      idx_q;
    logic [BW-1:0]                      bsa_q;
    logic [BW-1:0]                      bsb_q;
    logic                               err_q;
    logic [M-1:0][N-1:0][31:0]          acc_q;
    logic [M-1:0][K-1:0][MAX_WIDTH-1:0] a_q;
    logic [K-1:0][N-1:0][MAX_WIDTH-1:0] b_q;

    logic desc_bad;
    logic last_tile;
    logic desc_fire;
    logic op_fire;
    logic res_fire;

    assign desc_bad = (desc_bsa_i == '0) || (desc_bsa_i > MAX_BS)
                   || (desc_bsb_i == '0) || (desc_bsb_i > MAX_BS)
                   || (desc_tiles_i > MAX_T);

    assign last_tile = (idx_q + TW'(1)) == tiles_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Handshake ports decode purely from state, so only one is ever live.
    always_comb begin
        state_d      = state_q;
        desc_ready_o = 1'b0;
        op_ready_o   = 1'b0;
        mac_valid_o  = 1'b0;
        mac_ready_o  = 1'b0;
        res_valid_o  = 1'b0;
        unique case (state_q)
            IDLE: begin
                desc_ready_o = 1'b1;
                if (desc_valid_i) begin
                    if (desc_bad || desc_tiles_i == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d = FETCH;
                    end
                end
            end
            FETCH: begin
                op_ready_o = 1'b1;
                if (op_valid_i) state_d = LAUNCH;
            end
            LAUNCH: begin
                mac_valid_o = 1'b1;
                if (mac_ready_i) state_d = WAIT;
            end
            WAIT: begin
                mac_ready_o = 1'b1;
                if (mac_valid_i) begin
                    state_d = last_tile ? DONE : FETCH;
                end
            end
            DONE: begin
                res_valid_o = 1'b1;
                if (res_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign desc_fire = desc_ready_o & desc_valid_i;
    assign op_fire   = op_ready_o & op_valid_i;
    assign res_fire  = mac_ready_o & mac_valid_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tiles_q <= '0;
            idx_q   <= '0;
            bsa_q   <= '0;
            bsb_q   <= '0;
            err_q   <= 1'b0;
            acc_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            if (desc_fire) begin
                tiles_q <= desc_tiles_i;
                bsa_q   <= desc_bsa_i;
                bsb_q   <= desc_bsb_i;
                acc_q   <= desc_c_i;
                idx_q   <= '0;
                err_q   <= desc_bad;
            end
            if (op_fire) begin
                a_q <= op_a_i;
                b_q <= op_b_i;
            end
            // Bit-exact chaining: D of this tile is C of the next.
            if (res_fire) begin
                acc_q <= mac_d_i;
                idx_q <= idx_q + TW'(1);
            end
        end
    end

    assign mac_a_o    = a_q;
    assign mac_b_o    = b_q;
    assign mac_c_o    = acc_q;
    assign mac_bsa_o  = bsa_q;
    assign mac_bsb_o  = bsb_q;
    assign res_d_o    = acc_q;
    assign res_err_o  = err_q;
    assign busy_o     = (state_q != IDLE);
    assign tile_idx_o = idx_q;

endmodule

// File: tb/tb_seq_mac_tile_sched.sv
// Directed bench for seq_mac_tile_sched with a small
// behavioural MAC (fixed latency) on the mac_* ports.
module tb_seq_mac_tile_sched;

    typedef logic [1:0][1:0][31:0] mat32_t;
    typedef logic [1:0][1:0][15:0] mat16_t;

    localparam int MAC_LAT = 2;

    logic         clk_i;
    logic         rst_ni;
    logic         desc_valid_i;
    logic         desc_ready_o;
    logic [4:0]   desc_tiles_i;
    logic [3:0]   desc_bsa_i;
    logic [3:0]   desc_bsb_i;
    mat32_t       desc_c_i;
    logic         op_valid_i;
    logic         op_ready_o;
    mat16_t       op_a_i;
    mat16_t       op_b_i;
    mat16_t       mac_a_o;
    mat16_t       mac_b_o;
    mat32_t       mac_c_o;
    logic [3:0]   mac_bsa_o;
    logic [3:0]   mac_bsb_o;
    logic         mac_valid_o;
    logic         mac_ready_i;
    logic         mac_valid_i = 1'b0;
    logic         mac_ready_o;
    mat32_t       mac_d_i = '0;
    logic         res_valid_o;
    logic         res_ready_i;
    mat32_t       res_d_o;
    logic         res_err_o;
    logic         busy_o;
    logic [4:0]   tile_idx_o;

    seq_mac_tile_sched dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .desc_valid_i (desc_valid_i),
        .desc_ready_o (desc_ready_o),
        .desc_tiles_i (desc_tiles_i),
        .desc_bsa_i   (desc_bsa_i),
        .desc_bsb_i   (desc_bsb_i),
        .desc_c_i     (desc_c_i),
        .op_valid_i   (op_valid_i),
        .op_ready_o   (op_ready_o),
        .op_a_i       (op_a_i),
        .op_b_i       (op_b_i),
        .mac_a_o      (mac_a_o),
        .mac_b_o      (mac_b_o),
        .mac_c_o      (mac_c_o),
        .mac_bsa_o    (mac_bsa_o),
        .mac_bsb_o    (mac_bsb_o),
        .mac_valid_o  (mac_valid_o),
        .mac_ready_i  (mac_ready_i),
        .mac_valid_i  (mac_valid_i),
        .mac_ready_o  (mac_ready_o),
        .mac_d_i      (mac_d_i),
        .res_valid_o  (res_valid_o),
        .res_ready_i  (res_ready_i),
        .res_d_o      (res_d_o),
        .res_err_o    (res_err_o),
        .busy_o       (busy_o),
        .tile_idx_o   (tile_idx_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag,
                       input logic [255:0] got,
                       input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic mat16_t m16(int a, int b, int c, int d);
        mat16_t m;
        m[0][0] = 16'(a);
        m[0][1] = 16'(b);
        m[1][0] = 16'(c);
        m[1][1] = 16'(d);
        return m;
    endfunction

    function automatic mat32_t m32(int a, int b, int c, int d);
        mat32_t m;
        m[0][0] = 32'(a);
        m[0][1] = 32'(b);
        m[1][0] = 32'(c);
        m[1][1] = 32'(d);
        return m;
    endfunction

    function automatic mat32_t mac_fn(mat16_t a, mat16_t b, mat32_t c);
        mat32_t d;
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                int s;
                s = $signed(c[i][j]);
                for (int k = 0; k < 2; k++) begin
                    s += int'($signed(a[i][k])) * int'($signed(b[k][j]));
                end
                d[i][j] = 32'(s);
            end
        end
        return d;
    endfunction

    // Behavioural MAC: result appears MAC_LAT negedges after launch.
    int     launches = 0;
    int     ops      = 0;
    int     lat_cnt  = 0;
    logic   pend     = 1'b0;
    mat32_t d_pend   = '0;

    always @(posedge clk_i) begin
        if (!rst_ni) begin
            pend = 1'b0;
        end else begin
            if (mac_valid_i && mac_ready_o) pend = 1'b0;
            if (op_valid_i && op_ready_o) ops++;
            if (mac_valid_o && mac_ready_i) begin
                launches++;
                pend    = 1'b1;
                lat_cnt = MAC_LAT;
                d_pend  = mac_fn(mac_a_o, mac_b_o, mac_c_o);
            end
        end
    end

    always @(negedge clk_i) begin
        if (pend && lat_cnt > 0) lat_cnt--;
        mac_valid_i = pend && (lat_cnt == 0);
        mac_d_i     = mac_valid_i ? d_pend : '0;
    end

    task automatic send_desc(input int tiles, input int bsa,
                             input int bsb, input mat32_t c);
        int n = 0;
        desc_tiles_i = 5'(tiles);
        desc_bsa_i   = 4'(bsa);
        desc_bsb_i   = 4'(bsb);
        desc_c_i     = c;
        desc_valid_i = 1'b1;
        while (!desc_ready_o && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        chk("desc_timeout", 256'(n < 200), 1);
        @(negedge clk_i);
        desc_valid_i = 1'b0;
    endtask

    task automatic send_op(input mat16_t a, input mat16_t b,
                           input int stall);
        int   n  = 0;
        logic ok = 1'b1;
        op_valid_i = 1'b0;
        repeat (stall) begin
            @(negedge clk_i);
            if (!op_ready_o || mac_valid_o) ok = 1'b0;
        end
        if (stall > 0) chk("op_stall_hold", 256'(ok), 1);
        op_a_i     = a;
        op_b_i     = b;
        op_valid_i = 1'b1;
        while (!op_ready_o && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        chk("op_timeout", 256'(n < 200), 1);
        @(negedge clk_i);
        op_valid_i = 1'b0;
        chk("launch_next", 256'(mac_valid_o), 1);
    endtask

    task automatic get_res(input int stall, input mat32_t exp_d,
                           input logic exp_err, input int exp_idx,
                           input string tag);
        int     n  = 0;
        logic   ok = 1'b1;
        mat32_t d0;
        while (!res_valid_o && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        chk({tag, "_timeout"}, 256'(n < 200), 1);
        d0 = res_d_o;
        repeat (stall) begin
            @(negedge clk_i);
            if (!res_valid_o || res_d_o !== d0) ok = 1'b0;
        end
        if (stall > 0) chk({tag, "_hold"}, 256'(ok), 1);
        chk({tag, "_d"}, 256'(res_d_o), 256'(exp_d));
        chk({tag, "_err"}, 256'(res_err_o), 256'(exp_err));
        chk({tag, "_idx"}, 256'(tile_idx_o), 256'(exp_idx));
        res_ready_i = 1'b1;
        @(negedge clk_i);
        res_ready_i = 1'b0;
        chk({tag, "_drdy"}, 256'(desc_ready_o), 1);
    endtask

    int     l0;
    int     o0;
    int     n;
    logic   ok;
    mat16_t a5;
    mat16_t b5;
    mat32_t c5;

    initial begin
        rst_ni       = 1'b0;
        desc_valid_i = 1'b0;
        desc_tiles_i = '0;
        desc_bsa_i   = '0;
        desc_bsb_i   = '0;
        desc_c_i     = '0;
        op_valid_i   = 1'b0;
        op_a_i       = '0;
        op_b_i       = '0;
        mac_ready_i  = 1'b1;
        res_ready_i  = 1'b0;
        repeat (3) @(negedge clk_i);
        chk("rst_ctl", 256'({mac_valid_o, mac_ready_o, op_ready_o,
                             res_valid_o, busy_o, tile_idx_o}), 0);
        chk("rst_data", 256'({res_d_o, res_err_o}), 0);
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("rst_drdy", 256'(desc_ready_o), 1);

        // single tile
        l0 = launches;
        send_desc(1, 4, 4, m32(0, 0, 0, 0));
        chk("t1_oprdy_next", 256'(op_ready_o), 1);
        send_op(m16(1, 2, 3, 4), m16(1, 0, 0, 1), 0);
        chk("t1_bs", 256'({mac_bsa_o, mac_bsb_o}), 256'(8'h44));
        get_res(0, m32(1, 2, 3, 4), 1'b0, 1, "t1");
        chk("t1_launches", 256'(launches - l0), 1);

        // three-tile chaining
        send_desc(3, 4, 4, m32(10, 10, 10, 10));
        for (int t = 0; t < 3; t++) begin
            send_op(m16(2, 0, 0, 2), m16(3, 0, 0, 3), 0);
            if (t == 1) begin
                chk("t2_chain_c", 256'(mac_c_o),
                    256'(m32(16, 10, 10, 16)));
            end
        end
        get_res(0, m32(28, 10, 10, 28), 1'b0, 3, "t2");

        // signed operands, minimum A width
        send_desc(1, 1, 7, m32(5, 5, 5, 5));
        send_op(m16(-1, -1, -1, -1), m16(-64, 63, -64, 63), 0);
        get_res(0, m32(133, -121, 133, -121), 1'b0, 1, "t3");

        // zero tiles; op_valid held high must not be consumed
        l0 = launches;
        o0 = ops;
        op_valid_i = 1'b1;
        send_desc(0, 4, 4, m32(7, 7, 7, 7));
        chk("t4_res_next", 256'(res_valid_o), 1);
        get_res(0, m32(7, 7, 7, 7), 1'b0, 0, "t4");
        op_valid_i = 1'b0;
        chk("t4_no_pulses", 256'({launches - l0, ops - o0}), 0);

        // invalid descriptors
        send_desc(2, 0, 4, m32(1, 2, 3, 4));
        get_res(0, m32(1, 2, 3, 4), 1'b1, 0, "bsa0");
        send_desc(2, 4, 9, m32(9, 8, 7, 6));
        get_res(0, m32(9, 8, 7, 6), 1'b1, 0, "bsb9");
        send_desc(17, 4, 4, m32(3, 3, 3, 3));
        get_res(0, m32(3, 3, 3, 3), 1'b1, 0, "tiles17");
        chk("err_no_pulses", 256'({launches - l0, ops - o0}), 0);

        // backpressure on every port
        a5 = m16(1, 2, 3, 4);
        b5 = m16(5, 6, 7, 8);
        c5 = m32(100, 200, 300, 400);
        l0 = launches;
        send_desc(1, 4, 4, c5);
        mac_ready_i = 1'b0;
        send_op(a5, b5, 5);
        ok = 1'b1;
        repeat (4) begin
            @(negedge clk_i);
            if (!mac_valid_o || mac_a_o !== a5 || mac_b_o !== b5
                || mac_c_o !== c5) ok = 1'b0;
        end
        chk("bp_launch_hold", 256'(ok), 1);
        mac_ready_i = 1'b1;
        get_res(6, m32(119, 222, 343, 450), 1'b0, 1, "bp");
        chk("bp_launches", 256'(launches - l0), 1);

        // reset in WAIT of tile 2 of 3
        send_desc(3, 4, 4, m32(1, 1, 1, 1));
        send_op(m16(1, 0, 0, 1), m16(1, 0, 0, 1), 0);
        send_op(m16(1, 0, 0, 1), m16(1, 0, 0, 1), 0);
        n = 0;
        while (!mac_ready_o && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        chk("rst2_wait_timeout", 256'(n < 50), 1);
        chk("rst2_in_wait_idx", 256'(tile_idx_o), 1);
        rst_ni = 1'b0;
        #1;
        chk("rst2_ctl", 256'({mac_valid_o, mac_ready_o, op_ready_o,
                              res_valid_o, busy_o, tile_idx_o}), 0);
        chk("rst2_data", 256'({mac_a_o, mac_b_o, mac_c_o}), 0);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("rst2_drdy", 256'({desc_ready_o, busy_o}), 256'(2'b10));
        send_desc(1, 4, 4, m32(0, 0, 0, 0));
        send_op(m16(2, 0, 0, 2), m16(3, 0, 0, 3), 0);
        get_res(0, m32(6, 0, 0, 6), 1'b0, 1, "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
